// File: rtl/usr_ctrl.sv
// usr_ctrl: command/response sequencer for an external 4-bit universal shift
// register. A command loads, shifts or rotates the register. The resulting
// word is then offered on the response channel until it is consumed.
module usr_ctrl #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [3:0]       cmd_data,
    input  logic             cmd_fill,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_data,
    output logic             usr_rst,
    output logic [1:0]       usr_s,
    output logic [3:0]       usr_din,
    output logic             usr_sl_din,
    output logic             usr_sr_din,
    input  logic [3:0]       usr_dout
);

    localparam logic [1:0] OP_LOAD       = 2'b00;
    localparam logic [1:0] OP_SHIFT      = 2'b01;
    localparam logic [1:0] OP_ROTATE     = 2'b10;
    localparam logic [1:0] OP_LOAD_SHIFT = 2'b11;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_RIGHT = 2'b01;
    localparam logic [1:0] S_LEFT  = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

    typedef enum logic [1:0] {IDLE, LOAD, STEP, RESP} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ctr_q, ctr_d;
    logic [3:0]       data_q, data_d;
    logic             fill_q, fill_d;
    logic             usr_rst_q, usr_rst_d;
    logic             accept;

    // The register clear stays high for one cycle after reset is released,
    // so commands are held off until the register is known to be zero.
    assign accept   = cmd_valid && cmd_ready;
    assign rsp_data = usr_dout;
    assign usr_rst  = usr_rst_q;

    // Next-state, command latch and step down-counter
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        ctr_d     = ctr_q;
        data_d    = data_q;
        fill_d    = fill_q;
        usr_rst_d = !rst;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d   = cmd_op;
                    dir_d  = cmd_dir;
                    cnt_d  = cmd_cnt;
                    ctr_d  = cmd_cnt;
                    data_d = cmd_data;
                    fill_d = cmd_fill;
                    if (cmd_op == OP_LOAD || cmd_op == OP_LOAD_SHIFT)
                        state_d = LOAD;
                    else if (cmd_cnt != '0)
                        state_d = STEP;
                    else
                        state_d = RESP;
                end
            end
            LOAD: begin
                if (op_q == OP_LOAD_SHIFT && cnt_q != '0)
                    state_d = STEP;
                else
                    state_d = RESP;
            end
            STEP: begin
                // The counter holds the steps still to do, including this one
                ctr_d = ctr_q - CNT_W'(1);
                if (ctr_q <= CNT_W'(1))
                    state_d = RESP;
            end
            RESP: begin
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        usr_rst_q <= usr_rst_d;
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            ctr_q   <= '0;
            data_q  <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            ctr_q   <= ctr_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
        end
    end

    // Handshake and shift-register control decoded from the current state
    always_comb begin
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        usr_s      = S_HOLD;
        usr_din    = 4'h0;
        usr_sl_din = 1'b0;
        usr_sr_din = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: cmd_ready = !usr_rst_q;
                LOAD: begin
                    usr_s   = S_LOAD;
                    usr_din = data_q;
                end
                STEP: begin
                    usr_s = dir_q ? S_LEFT : S_RIGHT;
                    if (op_q == OP_ROTATE) begin
                        usr_sr_din = usr_dout[0];
                        usr_sl_din = usr_dout[3];
                    end else begin
                        usr_sr_din = fill_q;
                        usr_sl_din = fill_q;
                    end
                end
                RESP: rsp_valid = 1'b1;
                default: ;
            endcase
        end
    end

    logic unused_op;
    assign unused_op = (OP_SHIFT == 2'b01);

endmodule

// File: tb/tb_usr_ctrl.sv
// tb_usr_ctrl: randomized and directed checks of usr_ctrl against a
// behavioural result/latency model, with the shift register modelled here.
module tb_usr_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic       cmd_dir = 1'b0;
    logic [2:0] cmd_cnt = 3'd0;
    logic [3:0] cmd_data = 4'h0;
    logic       cmd_fill = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic       usr_rst;
    logic [1:0] usr_s;
    logic [3:0] usr_din;
    logic       usr_sl_din;
    logic       usr_sr_din;
    logic [3:0] reg_q = 4'h0;

    int total = 0;
    int bad = 0;
    logic [3:0] model_val = 4'h0;

    always #5 clk = ~clk;

    usr_ctrl #(.CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dir(cmd_dir), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .usr_rst(usr_rst), .usr_s(usr_s), .usr_din(usr_din),
        .usr_sl_din(usr_sl_din), .usr_sr_din(usr_sr_din), .usr_dout(reg_q)
    );

    // Universal shift register driven by the controller
    always @(posedge clk) begin
        if (usr_rst === 1'b1) reg_q <= 4'h0;
        else case (usr_s)
            2'b01: reg_q <= {usr_sr_din, reg_q[3:1]};
            2'b10: reg_q <= {reg_q[2:0], usr_sl_din};
            2'b11: reg_q <= usr_din;
            default: ;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_result(input logic [3:0] cur, input logic [1:0] op,
                                              input logic dir, input int cnt,
                                              input logic [3:0] data, input logic fill);
        int v;
        v = (op == 2'b00 || op == 2'b11) ? int'(data) : int'(cur);
        if (op != 2'b00) begin
            for (int i = 0; i < cnt; i++) begin
                if (op == 2'b10)
                    v = dir ? (((v << 1) | (v >> 3)) & 15) : ((v >> 1) | ((v & 1) << 3));
                else
                    v = dir ? (((v << 1) | int'(fill)) & 15) : ((v >> 1) | (int'(fill) << 3));
            end
        end
        return v[3:0];
    endfunction

    task automatic junk_cmd();
        cmd_op   = 2'($urandom_range(0, 3));
        cmd_dir  = 1'($urandom_range(0, 1));
        cmd_cnt  = 3'($urandom_range(0, 7));
        cmd_data = 4'($urandom_range(0, 15));
        cmd_fill = 1'($urandom_range(0, 1));
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic dir, input int cnt,
                          input logic [3:0] data, input logic fill, input int hold,
                          output logic [3:0] res);
        int waitc, lat, loads, steps, exp_lat, exp_steps, exp_loads;
        logic [3:0] exp_v, held;
        exp_v     = ref_result(model_val, op, dir, cnt, data, fill);
        exp_lat   = (op == 2'b00) ? 1 : (op == 2'b11) ? 1 + cnt : cnt;
        exp_loads = (op == 2'b00 || op == 2'b11) ? 1 : 0;
        exp_steps = (op == 2'b00) ? 0 : cnt;
        res = model_val;
        waitc = 0;
        while (cmd_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (cmd_ready !== 1'b1) begin
            check_eq("cmd_ready_wait", 32'(cmd_ready), 32'd1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op = op; cmd_dir = dir; cmd_cnt = 3'(cnt); cmd_data = data; cmd_fill = fill;
        @(negedge clk);
        cmd_valid = 1'b0;
        junk_cmd();
        check_eq("busy_cmd_ready", 32'(cmd_ready), 32'd0);
        lat = 0; loads = 0; steps = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            if (usr_s == 2'b11 && usr_din == data) loads++;
            if (usr_s == (dir ? 2'b10 : 2'b01) &&
                (op == 2'b10 || (usr_sl_din == fill && usr_sr_din == fill))) steps++;
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("load_cycles", 32'(loads), 32'(exp_loads));
        check_eq("step_cycles", 32'(steps), 32'(exp_steps));
        check_eq("rsp_data", 32'(rsp_data), 32'(exp_v));
        check_eq("resp_usr_s", 32'(usr_s), 32'd0);
        held = rsp_data;
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1;
            junk_cmd();
            @(negedge clk);
            check_eq("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold_rsp_data", 32'(rsp_data), 32'(held));
            check_eq("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check_eq("hold_usr_s", 32'(usr_s), 32'd0);
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        junk_cmd();
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_cmd_ready", 32'(cmd_ready), 32'd1);
        model_val = exp_v;
        res = held;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_usr_rst", 32'(usr_rst), 32'd1);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_usr_s", 32'(usr_s), 32'd0);
        check_eq("rst_usr_din", 32'(usr_din), 32'd0);
        check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("rel_usr_rst", 32'(usr_rst), 32'd1);
        check_eq("rel_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check_eq("rel2_usr_rst", 32'(usr_rst), 32'd0);
        check_eq("rel2_cmd_ready", 32'(cmd_ready), 32'd1);

        // Directed cases
        do_cmd(2'b00, 1'b0, 0, 4'hA, 1'b0, 0, r);
        check_eq("load_A", 32'(r), 32'hA);
        do_cmd(2'b11, 1'b0, 2, 4'b1011, 1'b0, 1, r);
        check_eq("load_shift", 32'(r), 32'b0010);
        do_cmd(2'b00, 1'b0, 0, 4'h9, 1'b0, 0, r);
        do_cmd(2'b10, 1'b1, 1, 4'h0, 1'b0, 0, r);
        check_eq("rot_l1", 32'(r), 32'h3);
        do_cmd(2'b10, 1'b1, 4, 4'h0, 1'b0, 0, r);
        check_eq("rot_l4", 32'(r), 32'h3);
        do_cmd(2'b10, 1'b0, 7, 4'h0, 1'b0, 0, r);
        check_eq("rot_r7", 32'(r), 32'h6);
        do_cmd(2'b01, 1'b1, 0, 4'hF, 1'b1, 0, r);
        check_eq("shift_cnt0", 32'(r), 32'h6);
        do_cmd(2'b01, 1'b1, 7, 4'h0, 1'b1, 5, r);
        check_eq("shift_l7_fill1", 32'(r), 32'hF);

        // Reset during STEP of a cnt=5 shift
        do_cmd(2'b00, 1'b0, 0, 4'h5, 1'b0, 0, r);
        cmd_valid = 1'b1;
        cmd_op = 2'b01; cmd_dir = 1'b0; cmd_cnt = 3'd5; cmd_data = 4'h0; cmd_fill = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("abort_usr_s", 32'(usr_s), 32'd0);
        check_eq("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("abort_usr_rst", 32'(usr_rst), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort_rel_usr_rst", 32'(usr_rst), 32'd1);
        check_eq("abort_rel_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check_eq("abort_rel2_usr_rst", 32'(usr_rst), 32'd0);
        check_eq("abort_rel2_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("abort_no_rsp", 32'(rsp_valid), 32'd0);
        model_val = 4'h0;
        do_cmd(2'b01, 1'b0, 0, 4'h0, 1'b0, 0, r);
        check_eq("abort_cleared", 32'(r), 32'h0);

        // Randomized commands
        for (int t = 0; t < 60; t++) begin
            do_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usr_ctrl.md
USR_CTRL -- requirements
Module: usr_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 3, width of the shift-count field (max count 2^CNT_W-1).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a posedge.
REQ-006 SHALL have port cmd_op  input  2  00 LOAD, 01 SHIFT, 10 ROTATE, 11 LOAD_SHIFT.
REQ-007 SHALL have port cmd_dir  input  1  0 right, 1 left.
REQ-008 SHALL have port cmd_cnt  input  CNT_W  number of shift/rotate steps.
REQ-009 SHALL have port cmd_data  input  4  parallel load value.
REQ-010 SHALL have port cmd_fill  input  1  serial fill bit for SHIFT/LOAD_SHIFT.
REQ-011 SHALL have port rsp_valid  output  1  result available.
REQ-012 SHALL have port rsp_ready  input  1  result consumed when rsp_valid && rsp_ready at a posedge.
REQ-013 SHALL have port rsp_data  output  4  result word.
REQ-014 SHALL have ports usr_rst (output, 1), usr_s (output, 2), usr_din (output, 4), usr_sl_din (output, 1), usr_sr_din (output, 1), usr_dout (input, 4): drive/observe the universal shift register.
REQ-015 SHALL treat the register as: s=00 hold, 01 dout<={sr_din,dout[3:1]}, 10 dout<={dout[2:0],sl_din}, 11 dout<=din; usr_rst active-high clear.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, STEP, RESP; cmd_ready=1 only in IDLE.
REQ-017 On acceptance, SHALL latch op, dir, cnt, data, fill into internal registers; cmd inputs are ignored at all other times.
REQ-018 From IDLE on acceptance: LOAD/LOAD_SHIFT -> LOAD; SHIFT/ROTATE with cnt!=0 -> STEP; SHIFT/ROTATE with cnt=0 -> RESP.
REQ-019 LOAD SHALL last exactly one cycle with usr_s=11, usr_din=latched data; then -> STEP if LOAD_SHIFT and cnt!=0, else -> RESP.
REQ-020 STEP SHALL last exactly cnt cycles; a down-counter loaded with cnt decrements each STEP cycle; -> RESP when it reaches 1.
REQ-021 In STEP, usr_s=01 for dir=0 and 10 for dir=1.
REQ-022 Fill: SHIFT/LOAD_SHIFT drive latched fill on both usr_sl_din and usr_sr_din; ROTATE drives usr_sr_din=usr_dout[0] and usr_sl_din=usr_dout[3] (combinational from usr_dout).
REQ-023 In IDLE and RESP, usr_s SHALL be 00; usr_din and serial inputs SHALL be 0 when unused.
REQ-024 Latency, acceptance at edge k: rsp_valid rises at edge k+L, where L=1 for LOAD, L=cnt for SHIFT/ROTATE, and L=1+cnt for LOAD_SHIFT.
REQ-025 In RESP, rsp_valid=1 and rsp_data=usr_dout; the result is stable because usr_s=00.
REQ-026 RESP SHALL hold indefinitely while rsp_ready=0, with rsp_valid and rsp_data unchanged.
REQ-027 On rsp_ready=1, SHALL go RESP -> IDLE; a cmd_valid in that same cycle is not accepted (cmd_ready=0); the earliest acceptance is the following edge.
REQ-028 rsp_valid SHALL be 0 in all states other than RESP.
REQ-029 cnt at maximum (7 for CNT_W=3) SHALL perform exactly 7 steps with no counter wrap.

Reset
REQ-030 While rst=0 at a posedge: state<=IDLE, counter<=0, latched fields<=0.
REQ-031 Outputs under reset: cmd_ready=0, rsp_valid=0, rsp_data=usr_dout, usr_s=00, usr_din=0, serial inputs 0.
REQ-032 usr_rst SHALL be registered: 1 while rst=0 and for the first cycle after rst returns to 1, then 0.
REQ-033 Reset asserted mid-operation (LOAD/STEP/RESP) SHALL abort the operation with no response issued.
REQ-034 cmd_ready SHALL be 1 from the second cycle after rst deasserts.

Verification
REQ-035 LOAD data=4'hA accepted at edge k -> usr_s=11 for one cycle; rsp_valid at k+1; rsp_data=4'hA.
REQ-036 LOAD_SHIFT data=4'b1011, dir=0, cnt=2, fill=0 -> two cycles with usr_s=01; rsp_valid at k+3; rsp_data=4'b0010.
REQ-037 After LOAD 4'h9: ROTATE dir=1 cnt=1 -> 4'h3; ROTATE dir=1 cnt=4 -> unchanged; ROTATE dir=0 cnt=7 -> correct value, no wrap.
REQ-038 SHIFT cnt=0 -> rsp_valid at edge k with unchanged usr_dout; usr_s stays 00.
REQ-039 rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp_valid/rsp_data stable, cmd_ready=0, usr_s=00; rsp_ready=1 -> IDLE, next command accepted one edge later.
REQ-040 rst=0 during STEP of a cnt=5 shift -> next edge: IDLE, rsp_valid=0, usr_s=00, usr_rst=1 through one cycle after release; no response.
